// File: rtl/pwm_multi_ctrl.sv
// Multi-channel PWM generator with debounced up/down duty buttons, direct duty write
// and period-aligned shadow->active duty loading. Optional: PWM_PHASE_STAGGER_EN.
module pwm_multi_ctrl #(
  parameter int NUM_CH     = 4,
  parameter int CNT_W      = 8,
  parameter int PERIOD     = 100,
  parameter int STEP       = 10,
  parameter int DUTY_INIT  = 50,
  parameter int DEB_DIV    = 4,
  parameter int DEB_STABLE = 3,
  localparam int SEL_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn_inc,
  input  logic              btn_dec,
  input  logic [SEL_W-1:0]  ch_sel,
  input  logic              duty_wr_en,
  input  logic [CNT_W-1:0]  duty_wr_data,
  output logic [CNT_W-1:0]  duty_rd,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              period_wrap
);

  localparam int DIV_W = (DEB_DIV > 1) ? $clog2(DEB_DIV) : 1;
  localparam int BTN_INC = 0;
  localparam int BTN_DEC = 1;

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W:0]   PERIOD_X   = (CNT_W + 1)'(PERIOD);
  localparam logic [CNT_W:0]   STEP_X     = (CNT_W + 1)'(STEP);
  localparam logic [CNT_W-1:0] DUTY_RST   = CNT_W'(DUTY_INIT);
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(DEB_DIV - 1);

  // ---------------------------------------------------------------------------
  // Button synchronisers and debounce
  // ---------------------------------------------------------------------------
  logic [1:0]            sync1_q, sync1_d;
  logic [1:0]            sync2_q, sync2_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic [DEB_STABLE-1:0] samp_q [2];
  logic [DEB_STABLE-1:0] samp_d [2];
  logic [1:0]            level_q, level_d;
  logic                  tick;
  logic [1:0]            press;

  always_comb begin
    // NOTE: every variable driven here gets a default before any branch, so no latch is inferred.
    sync1_d = {btn_dec, btn_inc};
    sync2_d = sync1_q;
    tick    = (div_q == DIV_LAST);
    div_d   = tick ? '0 : div_q + 1'b1;
    level_d = level_q;
    for (int b = 0; b < 2; b++) begin
      samp_d[b] = samp_q[b];
      if (tick) begin
        samp_d[b] = {samp_q[b][DEB_STABLE-2:0], sync2_q[b]};
        if (&samp_d[b]) begin
          level_d[b] = 1'b1;
        end else if (~|samp_d[b]) begin
          level_d[b] = 1'b0;
        end
      end
    end
    // A rising debounced level is the press; level only moves on a tick, so this is one cycle wide.
    press = level_d & ~level_q;
  end

  // ---------------------------------------------------------------------------
  // Shadow duty update: write > inc/dec collision > inc > dec
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] shadow_q [NUM_CH];
  logic [CNT_W-1:0] shadow_d [NUM_CH];
  logic [CNT_W:0]   sel_duty;
  logic [CNT_W:0]   wr_val;
  logic [CNT_W:0]   inc_val;
  logic [CNT_W:0]   dec_val;
  logic [CNT_W:0]   new_duty;
  logic             upd;

  always_comb begin
    sel_duty = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (SEL_W'(i) == ch_sel) begin
        sel_duty = {1'b0, shadow_q[i]};
      end
    end

    wr_val  = ({1'b0, duty_wr_data} > PERIOD_X) ? PERIOD_X : {1'b0, duty_wr_data};
    inc_val = ((sel_duty + STEP_X) > PERIOD_X) ? PERIOD_X : (sel_duty + STEP_X);
    dec_val = (sel_duty < STEP_X) ? '0 : (sel_duty - STEP_X);

    new_duty = sel_duty;
    upd      = 1'b0;
    if (duty_wr_en) begin
      new_duty = wr_val;
      upd      = 1'b1;
    end else if (press[BTN_INC] && press[BTN_DEC]) begin
      upd      = 1'b0;
    end else if (press[BTN_INC]) begin
      new_duty = inc_val;
      upd      = 1'b1;
    end else if (press[BTN_DEC]) begin
      new_duty = dec_val;
      upd      = 1'b1;
    end

    for (int i = 0; i < NUM_CH; i++) begin
      shadow_d[i] = shadow_q[i];
      if (upd && (SEL_W'(i) == ch_sel)) begin
        shadow_d[i] = CNT_W'(new_duty);
      end
    end
  end

  always_comb begin
    duty_rd = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (SEL_W'(i) == ch_sel) begin
        duty_rd = shadow_q[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Period counter, active duty load and PWM compare
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              wrap_q, wrap_d;
  logic              cnt_last;
  logic [CNT_W-1:0]  active_q [NUM_CH];
  logic [CNT_W-1:0]  active_d [NUM_CH];
  logic [NUM_CH-1:0] pwm_q, pwm_d;
  logic [CNT_W:0]    phase [NUM_CH];

  always_comb begin
    cnt_last = (cnt_q == CNT_LAST);
    cnt_d    = cnt_last ? '0 : cnt_q + 1'b1;
    wrap_d   = cnt_last;
    for (int i = 0; i < NUM_CH; i++) begin
      // Loading on the last count keeps every period whole at a single duty.
      active_d[i] = cnt_last ? shadow_q[i] : active_q[i];
`ifdef PWM_PHASE_STAGGER_EN
      phase[i] = {1'b0, cnt_q} + (CNT_W + 1)'(i * (PERIOD / NUM_CH));
      if (phase[i] >= PERIOD_X) begin
        phase[i] = phase[i] - PERIOD_X;
      end
`else
      phase[i] = {1'b0, cnt_q};
`endif
      pwm_d[i] = (phase[i] < {1'b0, active_q[i]});
    end
  end

  // NOTE: sequential state is assigned with <= only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      div_q   <= '0;
      level_q <= '0;
      cnt_q   <= '0;
      wrap_q  <= 1'b0;
      pwm_q   <= '0;
      for (int b = 0; b < 2; b++) begin
        samp_q[b] <= '0;
      end
      // NOTE: the duty arrays are small register files that must reset to a known duty, so each entry is reset explicitly.
      for (int i = 0; i < NUM_CH; i++) begin
        shadow_q[i] <= DUTY_RST;
        active_q[i] <= DUTY_RST;
      end
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      div_q   <= div_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      wrap_q  <= wrap_d;
      pwm_q   <= pwm_d;
      for (int b = 0; b < 2; b++) begin
        samp_q[b] <= samp_d[b];
      end
      for (int i = 0; i < NUM_CH; i++) begin
        shadow_q[i] <= shadow_d[i];
        active_q[i] <= active_d[i];
      end
    end
  end

  assign pwm_out     = pwm_q;
  assign period_wrap = wrap_q;

endmodule

// File: tb/tb_pwm_multi_ctrl.sv
// Self-checking bench for pwm_multi_ctrl: a cycle-level behavioural model is compared
// every cycle, and directed scenarios pin the model with hand-computed values.
module tb_pwm_multi_ctrl;

  localparam int NUM_CH     = 4;
  localparam int CNT_W      = 8;
  localparam int PERIOD     = 100;
  localparam int STEP       = 10;
  localparam int DUTY_INIT  = 50;
  localparam int DEB_DIV    = 2;
  localparam int DEB_STABLE = 3;
  localparam int SEL_W      = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              btn_inc = 1'b0;
  logic              btn_dec = 1'b0;
  logic [SEL_W-1:0]  ch_sel = '0;
  logic              duty_wr_en = 1'b0;
  logic [CNT_W-1:0]  duty_wr_data = '0;
  logic [CNT_W-1:0]  duty_rd;
  logic [NUM_CH-1:0] pwm_out;
  logic              period_wrap;

  pwm_multi_ctrl #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .PERIOD(PERIOD), .STEP(STEP),
    .DUTY_INIT(DUTY_INIT), .DEB_DIV(DEB_DIV), .DEB_STABLE(DEB_STABLE)
  ) dut (
    .clk(clk), .rst(rst), .btn_inc(btn_inc), .btn_dec(btn_dec), .ch_sel(ch_sel),
    .duty_wr_en(duty_wr_en), .duty_wr_data(duty_wr_data), .duty_rd(duty_rd),
    .pwm_out(pwm_out), .period_wrap(period_wrap)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_cnt, m_div;
  int m_shadow [NUM_CH];
  int m_active [NUM_CH];
  bit m_pwm    [NUM_CH];
  bit m_wrap;
  bit m_s1 [2], m_s2 [2], m_lev [2];
  bit m_hist [2][DEB_STABLE];   // most recent tick sample at index 0
  bit m_raw [2], m_press [2];
  bit m_tick;
  int m_ones, m_sel;

  function automatic int phase_of(input int i, input int c);
`ifdef PWM_PHASE_STAGGER_EN
    return (c + i * (PERIOD / NUM_CH)) % PERIOD;
`else
    return c + 0 * i;
`endif
  endfunction

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  always @(posedge clk) begin
    m_raw[0] = btn_inc;
    m_raw[1] = btn_dec;
    if (rst) begin
      m_cnt = 0; m_div = 0; m_wrap = 0;
      for (int i = 0; i < NUM_CH; i++) begin
        m_shadow[i] = DUTY_INIT; m_active[i] = DUTY_INIT; m_pwm[i] = 0;
      end
      for (int b = 0; b < 2; b++) begin
        m_s1[b] = 0; m_s2[b] = 0; m_lev[b] = 0;
        for (int k = 0; k < DEB_STABLE; k++) m_hist[b][k] = 0;
      end
    end else begin
      m_wrap = (m_cnt == PERIOD - 1);
      for (int i = 0; i < NUM_CH; i++) m_pwm[i] = (phase_of(i, m_cnt) < m_active[i]);
      if (m_cnt == PERIOD - 1)
        for (int i = 0; i < NUM_CH; i++) m_active[i] = m_shadow[i];
      m_cnt = (m_cnt + 1) % PERIOD;

      m_tick = (m_div == DEB_DIV - 1);
      m_div  = (m_div + 1) % DEB_DIV;
      for (int b = 0; b < 2; b++) begin
        m_press[b] = 0;
        if (m_tick) begin
          for (int k = DEB_STABLE - 1; k > 0; k--) m_hist[b][k] = m_hist[b][k-1];
          m_hist[b][0] = m_s2[b];
          m_ones = 0;
          for (int k = 0; k < DEB_STABLE; k++) m_ones += m_hist[b][k];
          if (m_ones == DEB_STABLE) begin
            m_press[b] = !m_lev[b];
            m_lev[b] = 1;
          end else if (m_ones == 0) begin
            m_lev[b] = 0;
          end
        end
        m_s2[b] = m_s1[b];
        m_s1[b] = m_raw[b];
      end

      m_sel = int'(ch_sel);
      if (m_sel < NUM_CH) begin
        if (duty_wr_en) m_shadow[m_sel] = min_i(int'(duty_wr_data), PERIOD);
        else if (m_press[0] && m_press[1]) m_shadow[m_sel] = m_shadow[m_sel];
        else if (m_press[0]) m_shadow[m_sel] = min_i(m_shadow[m_sel] + STEP, PERIOD);
        else if (m_press[1]) m_shadow[m_sel] = (m_shadow[m_sel] < STEP) ? 0 : m_shadow[m_sel] - STEP;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [NUM_CH-1:0] exp_pwm;
  int exp_rd;
  always @(negedge clk) begin
    if (cmp_en) begin
      for (int i = 0; i < NUM_CH; i++) exp_pwm[i] = m_pwm[i];
      exp_rd = (int'(ch_sel) < NUM_CH) ? m_shadow[int'(ch_sel)] : 0;
      check("model_pwm_out", 32'(pwm_out), 32'(exp_pwm));
      check("model_period_wrap", 32'(period_wrap), 32'(m_wrap));
      check("model_duty_rd", 32'(duty_rd), 32'(exp_rd));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; btn_inc = 1'b0; btn_dec = 1'b0; duty_wr_en = 1'b0;
    step(2);
    rst = 1'b0;
  endtask

  task automatic write_duty(input int v);
    duty_wr_en = 1'b1; duty_wr_data = CNT_W'(v);
    step(1);
    duty_wr_en = 1'b0;
  endtask

  // which: 0 = inc, 1 = dec, 2 = both together
  task automatic press_btn(input int which, input int hold);
    btn_inc = (which != 1);
    btn_dec = (which != 0);
    step(hold);
    btn_inc = 1'b0; btn_dec = 1'b0;
    step(20);
  endtask

  task automatic wait_wrap(input string name);
    bit seen = 1'b0;
    for (int k = 0; k < 250 && !seen; k++) begin
      step(1);
      seen = period_wrap;
    end
    if (!seen) check({name, "_wrap_timeout"}, 32'd0, 32'd1);
  endtask

  // High cycles of one channel over a full period in which the active duty is stable.
  task automatic count_period(input int ch, input string name, output int n);
    wait_wrap(name);
    n = 0;
    repeat (PERIOD) begin
      step(1);
      n += int'(pwm_out[ch]);
    end
  endtask

  task automatic wait_cnt(input int target);
    bit hit = 1'b0;
    for (int k = 0; k < 250 && !hit; k++) begin
      step(1);
      hit = (m_cnt == target);
    end
    if (!hit) check("wait_cnt_timeout", 32'd0, 32'd1);
  endtask

  // ---------------- test sequence ----------------
  int hi [NUM_CH];
  int wraps, n, gap;
  bit tgt_inc, tgt_dec;

  initial begin
    step(3);
    cmp_en = 1'b1;
    check("reset_pwm_out", 32'(pwm_out), 32'd0);
    check("reset_period_wrap", 32'(period_wrap), 32'd0);
    check("reset_duty_rd", 32'(duty_rd), 32'd50);

    // Defaults: 300 cycles give 3 whole periods at 50 %.
    rst = 1'b0;
    wraps = 0;
    for (int i = 0; i < NUM_CH; i++) hi[i] = 0;
    for (int k = 0; k < 300; k++) begin
      step(1);
      for (int i = 0; i < NUM_CH; i++) hi[i] += int'(pwm_out[i]);
      wraps += int'(period_wrap);
    end
    for (int i = 0; i < NUM_CH; i++) check($sformatf("default_high_ch%0d", i), 32'(hi[i]), 32'd150);
    check("default_wraps", 32'(wraps), 32'd3);

    // Randomised traffic: bouncy buttons, random writes and channel selects, rare resets.
    tgt_inc = 0; tgt_dec = 0;
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 39) == 0) tgt_inc = ~tgt_inc;
      if ($urandom_range(0, 39) == 0) tgt_dec = ~tgt_dec;
      btn_inc = ($urandom_range(0, 5) == 0) ? ~tgt_inc : tgt_inc;
      btn_dec = ($urandom_range(0, 5) == 0) ? ~tgt_dec : tgt_dec;
      if ($urandom_range(0, 19) == 0) ch_sel = SEL_W'($urandom_range(0, NUM_CH - 1));
      duty_wr_en   = ($urandom_range(0, 49) == 0);
      duty_wr_data = CNT_W'($urandom_range(0, 255));
      rst          = ($urandom_range(0, 1499) == 0);
      step(1);
    end
    duty_wr_en = 1'b0;
    do_reset();

    // Clean press on channel 1; takes effect from the next period only.
    ch_sel = 2'd1;
    press_btn(0, 20);
    check("inc_ch1_duty", 32'(duty_rd), 32'd60);
    count_period(1, "inc_ch1", n);
    check("inc_ch1_high", 32'(n), 32'd60);
    count_period(0, "inc_ch0", n);
    check("other_ch0_high", 32'(n), 32'd50);
    ch_sel = 2'd0; step(1);
    check("other_ch0_duty", 32'(duty_rd), 32'd50);

    // Bounce every 3 cycles for 30 cycles, then a steady hold: one increment only.
    ch_sel = 2'd2;
    for (int k = 0; k < 10; k++) begin
      btn_inc = (k % 2 == 0);
      step(3);
    end
    press_btn(0, 20);
    check("bounce_ch2_duty", 32'(duty_rd), 32'd60);

    // Upper saturation.
    ch_sel = 2'd3;
    write_duty(95);
    check("write95_duty", 32'(duty_rd), 32'd95);
    press_btn(0, 20);
    check("sat_inc1_duty", 32'(duty_rd), 32'd100);
    press_btn(0, 20);
    check("sat_inc2_duty", 32'(duty_rd), 32'd100);
    count_period(3, "sat_ch3", n);
    check("sat_ch3_high", 32'(n), 32'd100);
    write_duty(200);
    check("write200_duty", 32'(duty_rd), 32'd100);

    // Lower saturation and simultaneous inc/dec.
    ch_sel = 2'd0;
    write_duty(5);
    press_btn(1, 20);
    check("dec_sat_duty", 32'(duty_rd), 32'd0);
    count_period(0, "zero_ch0", n);
    check("zero_ch0_high", 32'(n), 32'd0);
    write_duty(40);
    press_btn(2, 20);
    check("both_press_duty", 32'(duty_rd), 32'd40);

    // Reset mid-period.
    wait_cnt(40);
    write_duty(30);
    check("midwrite_duty", 32'(duty_rd), 32'd30);
    wait_cnt(70);
    rst = 1'b1;
    step(1);
    check("midreset_pwm_out", 32'(pwm_out), 32'd0);
    for (int s = 0; s < NUM_CH; s++) begin
      ch_sel = SEL_W'(s);
      step(1);
      check($sformatf("midreset_duty_ch%0d", s), 32'(duty_rd), 32'd50);
    end
    rst = 1'b0;
    gap = 0;
    for (int k = 1; k <= 200 && gap == 0; k++) begin
      step(1);
      if (period_wrap) gap = k;
    end
    check("restart_first_wrap", 32'(gap), 32'd100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
